// File: rtl/imm_encoder.sv
// imm_encoder: finds a 16-bit imm/EOp pair that the immediate extender expands
// back to a 32-bit constant, falling back to a lui + zero-extend OR pair.
module imm_encoder #(
    parameter logic [3:0] MODE_MASK = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_split,
    output logic        out_last
);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        EMIT,
        HI,
        LO
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] v_q, v_d;
    logic [15:0] imm_q, imm_d;
    logic [1:0]  eop_q, eop_d;
    logic        split_q, split_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;

    logic        hit;
    logic        hit_en;
    logic [15:0] cand;

    // Test the latched word against the extender mode selected by k.
    always_comb begin
        hit  = 1'b0;
        cand = 16'h0000;
        unique case (k_q)
            2'd0: begin
                hit  = (&v_q[31:15]) | ~(|v_q[31:15]);
                cand = v_q[15:0];
            end
            2'd1: begin
                hit  = ~(|v_q[31:16]);
                cand = v_q[15:0];
            end
            2'd2: begin
                hit  = ~(|v_q[15:0]);
                cand = v_q[31:16];
            end
            2'd3: begin
                hit  = ~(|v_q[1:0]) &
                       ((&v_q[31:17]) | ~(|v_q[31:17]));
                cand = v_q[17:2];
            end
        endcase
        hit_en = hit & MODE_MASK[k_q];
    end

    // Next-state and output-register logic for the search/emit sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        v_d     = v_q;
        imm_d   = imm_q;
        eop_d   = eop_q;
        split_d = split_q;
        last_d  = last_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    v_d     = in_data;
                    k_d     = 2'd0;
                    state_d = CHK;
                end
            end
            CHK: begin
                if (hit_en) begin
                    imm_d   = cand;
                    eop_d   = k_q;
                    split_d = 1'b0;
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else if (k_q != 2'd3) begin
                    k_d = k_q + 2'd1;
                end else begin
                    imm_d   = v_q[31:16];
                    eop_d   = 2'b10;
                    split_d = 1'b1;
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = HI;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            HI: begin
                if (out_ready) begin
                    imm_d   = v_q[15:0];
                    eop_d   = 2'b01;
                    split_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = LO;
                end
            end
            LO: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            v_q     <= 32'h0;
            imm_q   <= 16'h0;
            eop_q   <= 2'b00;
            split_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            v_q     <= v_d;
            imm_q   <= imm_d;
            eop_q   <= eop_d;
            split_q <= split_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_imm   = imm_q;
    assign out_eop   = eop_q;
    assign out_split = split_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against a
// value-level model of the immediate extender.
`timescale 1ns/1ps
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_split;
    logic        out_last;

    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [31:0] m_in_data = 32'h0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [15:0] m_out_imm;
    logic [1:0]  m_out_eop;
    logic        m_out_split;
    logic        m_out_last;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        split;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_eop(out_eop),
        .out_split(out_split), .out_last(out_last)
    );

    imm_encoder #(.MODE_MASK(4'b1110)) dut_m (
        .clk(clk), .reset(reset),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_imm(m_out_imm), .out_eop(m_out_eop),
        .out_split(m_out_split), .out_last(m_out_last)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Value-level model: which extender op rebuilds v, in priority order.
    task automatic model(input logic [31:0] v, input logic [3:0] mask,
                         output int n, output int lat,
                         output logic [15:0] imm0, output logic [1:0] eop0,
                         output logic [15:0] imm1);
        longint s;
        s = longint'($signed(v));
        n = 1;
        imm1 = 16'h0;
        if (mask[0] && s >= -32768 && s <= 32767) begin
            lat = 1; eop0 = 2'd0; imm0 = 16'(s);
        end else if (mask[1] && v < 32'd65536) begin
            lat = 2; eop0 = 2'd1; imm0 = 16'(v);
        end else if (mask[2] && (v % 32'd65536) == 0) begin
            lat = 3; eop0 = 2'd2; imm0 = 16'(v / 32'd65536);
        end else if (mask[3] && (v % 32'd4) == 0 &&
                     s / 4 >= -32768 && s / 4 <= 32767) begin
            lat = 4; eop0 = 2'd3; imm0 = 16'(s / 4);
        end else begin
            n = 2; lat = 4; eop0 = 2'd2;
            imm0 = 16'(v / 32'd65536);
            imm1 = 16'(v % 32'd65536);
        end
    endtask

    // Compare process: retiring beats, hold-under-stall, in_ready while busy.
    logic  stall_prev = 1'b0;
    beat_t prev_b;
    beat_t cur_b;
    beat_t e_b;
    always @(negedge clk) begin
        cur_b = '{out_imm, out_eop, out_split, out_last};
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_beat", 32'(cur_b), 32'(prev_b));
            end
            if (out_valid)
                check("busy_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e_b = exp_q.pop_front();
                    check("beat", 32'(cur_b), 32'(e_b));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_b = cur_b;
        end
    end

    task automatic poke();
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
    endtask

    task automatic encode(input logic [31:0] v, input int stall);
        int n, lat, e;
        logic [15:0] i0, i1;
        logic [1:0] e0;
        model(v, 4'b1111, n, lat, i0, e0, i1);
        exp_q.push_back('{i0, e0, n == 2, n == 1});
        if (n == 2) exp_q.push_back('{i1, 2'd1, 1'b1, 1'b1});
        out_ready = (stall == 0);
        in_valid = 1'b1;
        in_data = v;
        @(posedge clk); #1;
        poke();
        for (int j = 0; j < n; j++) begin
            e = 0;
            while (!out_valid && e < 20) begin
                @(posedge clk); #1; e++; poke();
            end
            check(j == 0 ? "lat_first" : "lat_second", e, j == 0 ? lat : 0);
            if (!out_valid) break;
            if (j == 0 && stall > 0) begin
                repeat (stall) begin
                    @(posedge clk); #1; poke();
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1; poke();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("done_queue", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic m_encode(input logic [31:0] v, input logic [15:0] imm,
                            input logic [1:0] eop, input int lat);
        int e;
        m_in_valid = 1'b1;
        m_in_data = v;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        e = 0;
        while (!m_out_valid && e < 20) begin
            @(posedge clk); #1; e++;
        end
        check("mask_lat", e, lat);
        check("mask_beat",
              32'({m_out_imm, m_out_eop, m_out_split, m_out_last}),
              32'({imm, eop, 1'b0, 1'b1}));
        @(posedge clk); #1;
        check("mask_idle", 32'({m_in_ready, m_out_valid}), 32'b10);
    endtask

    task automatic pin(input logic [31:0] v, input int n_x, input int lat_x,
                       input logic [15:0] i0_x, input logic [1:0] e0_x,
                       input logic [15:0] i1_x, input logic [3:0] mask);
        int n, lat;
        logic [15:0] i0, i1;
        logic [1:0] e0;
        model(v, mask, n, lat, i0, e0, i1);
        check("model", 32'({n[1:0], lat[2:0], i0, e0}),
              32'({n_x[1:0], lat_x[2:0], i0_x, e0_x}));
        if (n == 2) check("model_lo", 32'(i1), 32'(i1_x));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, r;
        int stall;

        pin(32'h00007FFF, 1, 1, 16'h7FFF, 2'd0, 16'h0, 4'hF);
        pin(32'h0000FFFF, 1, 2, 16'hFFFF, 2'd1, 16'h0, 4'hF);
        pin(32'hFFFF8000, 1, 1, 16'h8000, 2'd0, 16'h0, 4'hF);
        pin(32'h12340000, 1, 3, 16'h1234, 2'd2, 16'h0, 4'hF);
        pin(32'h0001FFFC, 1, 4, 16'h7FFF, 2'd3, 16'h0, 4'hF);
        pin(32'h12345678, 2, 4, 16'h1234, 2'd2, 16'h5678, 4'hF);
        pin(32'h00000005, 1, 2, 16'h0005, 2'd1, 16'h0, 4'b1110);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              32'({in_ready, out_valid, out_imm, out_eop, out_split, out_last}),
              32'({1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0}));
        reset = 1'b0;

        encode(32'h00007FFF, 0);
        encode(32'h0000FFFF, 0);
        encode(32'hFFFF8000, 0);
        encode(32'h00000000, 0);
        encode(32'h12340000, 0);
        encode(32'h0001FFFC, 0);
        encode(32'h12345678, 0);
        encode(32'h12345678, 5);
        encode(32'h80000000, 2);
        encode(32'hFFFFFFFF, 0);

        in_valid = 1'b1;
        in_data = 32'h0001FFFC;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_chk",
              32'({in_ready, out_valid, out_imm, out_eop, out_split, out_last}),
              32'({1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0}));
        encode(32'h00007FFF, 0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("in_hi", 32'({out_valid, out_split, out_last, out_imm}),
              32'({1'b1, 1'b1, 1'b0, 16'h1234}));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        check("rst_hi",
              32'({in_ready, out_valid, out_imm, out_eop, out_split, out_last}),
              32'({1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0}));
        encode(32'h12340000, 0);

        m_encode(32'h00000005, 16'h0005, 2'd1, 2);
        m_encode(32'h00000000, 16'h0000, 2'd1, 2);
        m_encode(32'hFFFF8000, 16'hE000, 2'd3, 4);

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: v = {{16{r[15]}}, r[15:0]};
                1: v = {16'h0, r[15:0]};
                2: v = {r[15:0], 16'h0};
                3: v = {{14{r[17]}}, r[17:2], 2'b00};
                default: v = r;
            endcase
            stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            encode(v, stall);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
